// File: rtl/package_param_streamer.sv
// Two-requester round-robin streamer that emits package-parameter constants as
// 32-bit words over a valid/ready port, one burst per grant.
package cocotb_package_pkg_1;
  localparam int          five_int    = 5;
  localparam logic [7:0]  eight_logic = 8'd8;
  localparam logic [63:0] long_param  = 64'hFFFF_FFFF_FFFF_FFFF;
endpackage

package cocotb_package_pkg_2;
  localparam int eleven_int = 11;
endpackage

localparam int unit_four_int = 4;

module package_param_streamer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  output logic [1:0]        gnt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W:0]    out_tag,
  output logic              out_last,
  output logic              busy,
  output logic [1:0]        done
);

  localparam logic [IDX_W-1:0] A_LAST = IDX_W'(3);
  localparam logic [IDX_W-1:0] B_LAST = IDX_W'(1);

  if (DATA_W != 32) begin : g_bad_width
    $error("package_param_streamer: only DATA_W == 32 is supported");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_DONE} state_t;

  // Word table: set A (src 0) then set B (src 1), sourced from the packages.
  function automatic logic [DATA_W-1:0] word_of(input logic s, input logic [IDX_W-1:0] i);
    logic [DATA_W-1:0] w;
    w = '0;
    if (!s) begin
      case (i)
        IDX_W'(0): w = DATA_W'(cocotb_package_pkg_1::five_int);
        IDX_W'(1): w = DATA_W'(cocotb_package_pkg_1::eight_logic);
        IDX_W'(2): w = DATA_W'(cocotb_package_pkg_1::long_param[31:0]);
        default:   w = DATA_W'(cocotb_package_pkg_1::long_param[63:32]);
      endcase
    end else begin
      w = (i == IDX_W'(0)) ? DATA_W'(cocotb_package_pkg_2::eleven_int)
                           : DATA_W'(unit_four_int);
    end
    return w;
  endfunction

  function automatic logic last_of(input logic s, input logic [IDX_W-1:0] i);
    return s ? (i == B_LAST) : (i == A_LAST);
  endfunction

  state_t            state, state_nxt;
  logic              src, src_nxt;
  logic              rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt, idx_inc;
  logic              sel, beat;
  logic [1:0]        gnt_nxt, done_nxt;
  logic              out_valid_nxt, out_last_nxt, busy_nxt;
  logic [DATA_W-1:0] out_data_nxt;
  logic [IDX_W:0]    out_tag_nxt;

  // Next-state and registered-output decode; outputs hold unless updated.
  always_comb begin
    state_nxt     = state;
    src_nxt       = src;
    rr_ptr_nxt    = rr_ptr;
    idx_nxt       = idx;
    gnt_nxt       = gnt;
    done_nxt      = 2'b00;
    out_valid_nxt = out_valid;
    out_data_nxt  = out_data;
    out_tag_nxt   = out_tag;
    out_last_nxt  = out_last;
    sel           = req[rr_ptr] ? rr_ptr : ~rr_ptr;
    beat          = out_valid & out_ready;
    idx_inc       = idx + IDX_W'(1);

    case (state)
      ST_IDLE: begin
        if (req != 2'b00) begin
          state_nxt     = ST_SEND;
          src_nxt       = sel;
          idx_nxt       = '0;
          gnt_nxt       = sel ? 2'b10 : 2'b01;
          out_valid_nxt = 1'b1;
          out_data_nxt  = word_of(sel, '0);
          out_tag_nxt   = {sel, IDX_W'(0)};
          out_last_nxt  = last_of(sel, '0);
        end
      end
      ST_SEND: begin
        if (beat) begin
          if (out_last) begin
            state_nxt     = ST_DONE;
            gnt_nxt       = 2'b00;
            out_valid_nxt = 1'b0;
            out_last_nxt  = 1'b0;
            done_nxt      = src ? 2'b10 : 2'b01;
          end else begin
            idx_nxt      = idx_inc;
            out_data_nxt = word_of(src, idx_inc);
            out_tag_nxt  = {src, idx_inc};
            out_last_nxt = last_of(src, idx_inc);
          end
        end
      end
      ST_DONE: begin
        // Hand priority to the other side so a held request cannot starve it.
        rr_ptr_nxt = ~src;
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    busy_nxt = (state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      src       <= 1'b0;
      rr_ptr    <= 1'b0;
      idx       <= '0;
      gnt       <= 2'b00;
      done      <= 2'b00;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      src       <= src_nxt;
      rr_ptr    <= rr_ptr_nxt;
      idx       <= idx_nxt;
      gnt       <= gnt_nxt;
      done      <= done_nxt;
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
      out_tag   <= out_tag_nxt;
      out_last  <= out_last_nxt;
      busy      <= busy_nxt;
      // Set B is two words long; its upper index values must never be reached.
      if (state == ST_SEND) assert (!src || idx <= B_LAST);
    end
  end

endmodule

// File: tb/tb_package_param_streamer.sv
// Directed self-checking bench for package_param_streamer: bursts, arbitration,
// back-pressure, request drop and mid-burst reset.
module tb_package_param_streamer;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  gnt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_tag;
  logic        out_last;
  logic        busy;
  logic [1:0]  done;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_a [4];
  logic [31:0] exp_b [2];
  int          stall_idx [7];
  logic        stall_rdy [7];

  package_param_streamer #(.DATA_W(32), .IDX_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Called at a negedge one cycle before the first word is due; returns at the
  // IDLE negedge after the done pulse. Drops req at beat index clr_at.
  task automatic run_burst(input logic s, input int clr_at);
    int len;
    len = s ? 2 : 4;
    @(negedge clk);
    for (int i = 0; i < len; i++) begin
      if (i > 0) @(negedge clk);
      if (i == clr_at) req = 2'b00;
      chk("burst_valid", 64'(out_valid), 64'(1'b1));
      chk("burst_gnt",   64'(gnt), s ? 64'(2'b10) : 64'(2'b01));
      chk("burst_data",  64'(out_data), s ? 64'(exp_b[i]) : 64'(exp_a[i]));
      chk("burst_tag",   64'(out_tag), 64'({s, 2'(i)}));
      chk("burst_last",  64'(out_last), 64'(i == len - 1));
      chk("burst_busy",  64'(busy), 64'(1'b1));
    end
    @(negedge clk);
    chk("done_pulse", 64'(done), s ? 64'(2'b10) : 64'(2'b01));
    chk("done_valid", 64'(out_valid), 64'(1'b0));
    chk("done_gnt",   64'(gnt), 64'(2'b00));
    @(negedge clk);
    chk("gap_done",  64'(done), 64'(2'b00));
    chk("gap_valid", 64'(out_valid), 64'(1'b0));
    chk("gap_busy",  64'(busy), 64'(1'b0));
  endtask

  initial begin
    exp_a     = '{32'd5, 32'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    exp_b     = '{32'd11, 32'd4};
    stall_rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    stall_idx = '{0, 1, 1, 1, 2, 2, 3};

    rst = 1'b1; req = 2'b00; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_gnt",   64'(gnt), 64'(2'b00));
    chk("rst_valid", 64'(out_valid), 64'(1'b0));
    chk("rst_data",  64'(out_data), 64'(32'd0));
    chk("rst_tag",   64'(out_tag), 64'(3'd0));
    chk("rst_last",  64'(out_last), 64'(1'b0));
    chk("rst_busy",  64'(busy), 64'(1'b0));
    chk("rst_done",  64'(done), 64'(2'b00));
    rst = 1'b0;
    @(negedge clk);

    // Set A alone, request for one cycle.
    req = 2'b01; out_ready = 1'b1;
    run_burst(1'b0, 0);

    // Set B alone.
    req = 2'b10;
    run_burst(1'b1, 0);

    // Both held: strict alternation A, B, A, B with a two-cycle gap.
    req = 2'b11;
    run_burst(1'b0, 7);
    run_burst(1'b1, 7);
    run_burst(1'b0, 7);
    run_burst(1'b1, 0);

    // Back-pressure on set A: words held stable through stalls.
    req = 2'b01;
    @(negedge clk);
    req = 2'b00;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      out_ready = stall_rdy[i];
      chk("stall_valid", 64'(out_valid), 64'(1'b1));
      chk("stall_data",  64'(out_data), 64'(exp_a[stall_idx[i]]));
      chk("stall_tag",   64'(out_tag), 64'({1'b0, 2'(stall_idx[i])}));
      chk("stall_last",  64'(out_last), 64'(stall_idx[i] == 3));
    end
    @(negedge clk);
    out_ready = 1'b1;
    chk("stall_done",  64'(done), 64'(2'b01));
    chk("stall_valid_off", 64'(out_valid), 64'(1'b0));
    @(negedge clk);

    // Request dropped after the first accepted beat; burst still completes.
    req = 2'b01;
    run_burst(1'b0, 1);

    // Reset after two beats of A.
    req = 2'b01;
    @(negedge clk);
    req = 2'b00;
    chk("rst_mid_beat1", 64'(out_data), 64'(32'd5));
    @(negedge clk);
    chk("rst_mid_beat2", 64'(out_data), 64'(32'd8));
    @(negedge clk);
    chk("rst_mid_beat3", 64'(out_data), 64'(32'hFFFF_FFFF));
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", 64'(out_valid), 64'(1'b0));
    chk("rst_mid_gnt",   64'(gnt), 64'(2'b00));
    chk("rst_mid_data",  64'(out_data), 64'(32'd0));
    chk("rst_mid_tag",   64'(out_tag), 64'(3'd0));
    chk("rst_mid_busy",  64'(busy), 64'(1'b0));
    @(negedge clk);
    chk("rst_mid_done",  64'(done), 64'(2'b00));
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_nodone", 64'(done), 64'(2'b00));
    req = 2'b01;
    run_burst(1'b0, 0);

    // Ready high with nothing pending is ignored.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_valid", 64'(out_valid), 64'(1'b0));
      chk("idle_busy",  64'(busy), 64'(1'b0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
